// File: rtl/char_conv_if.sv
// rtl/char_conv_if.sv - start/in launch and out/busy/done result bundle for char_conv
interface char_conv_if #(
    parameter int WIDTH  = 30,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [WIDTH-1:0]      in;
    logic [6*DIGITS-1:0]   out;
    logic                  busy;
    logic                  done;

    // Control sequencer side: launches a conversion and collects the characters
    modport master (
        output start,
        output in,
        input  out,
        input  busy,
        input  done
    );

    // Converter side
    modport slave (
        input  start,
        input  in,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/char_conv.sv
// rtl/char_conv.sv - MIX CHAR binary-to-character converter (double-dabble), CHAR_FAST_EN selects 2 bits/cycle
module char_conv #(
    parameter int WIDTH  = 30,
    parameter int DIGITS = 10
) (
    input  logic         clk,
    input  logic         reset,
    char_conv_if.slave   bus
);
    localparam int BCDW = 4 * DIGITS;
`ifdef CHAR_FAST_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam int ITERS = WIDTH / STEPS;
    localparam logic [4:0] LAST = 5'(ITERS - 1);
    localparam logic [6*DIGITS-1:0] ZERO_OUT = {DIGITS{6'd30}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state, state_n;
    logic [WIDTH-1:0]      bin, bin_n, bin_s;
    logic [BCDW-1:0]       bcd, bcd_n, bcd_s;
    logic [4:0]            cnt, cnt_n;
    logic [6*DIGITS-1:0]   out_r, out_n;
    logic                  busy_r, busy_n;
    logic                  done_r, done_n;

    // Nibbles of 5 or more become 8+ after the next shift, so pre-add 3 to carry into the next decade
    function automatic logic [BCDW-1:0] add3(input logic [BCDW-1:0] b);
        logic [BCDW-1:0] r;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Digit d becomes MIX character code 30+d; nibble 9 lands in the top byte
    function automatic logic [6*DIGITS-1:0] to_chars(input logic [BCDW-1:0] b);
        logic [6*DIGITS-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[6*k +: 6] = 6'd30 + {2'b00, b[4*k +: 4]};
        end
        return r;
    endfunction

    // One SHIFT cycle worth of adjust-and-shift steps, chained when two bits per cycle
    always_comb begin
        bcd_s = bcd;
        bin_s = bin;
        for (int s = 0; s < STEPS; s++) begin
            bcd_s = add3(bcd_s);
            {bcd_s, bin_s} = {bcd_s[BCDW-2:0], bin_s, 1'b0};
        end
    end

    // Next-state and datapath updates; the final shift writes out directly so there is no FINISH state
    always_comb begin
        state_n = state;
        bin_n   = bin;
        bcd_n   = bcd;
        cnt_n   = cnt;
        out_n   = out_r;
        busy_n  = busy_r;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    bin_n   = bus.in;
                    bcd_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                bin_n = bin_s;
                bcd_n = bcd_s;
                cnt_n = cnt + 5'd1;
                if (cnt == LAST) begin
                    out_n   = to_chars(bcd_s);
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion without a done
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            out_r  <= ZERO_OUT;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            bin    <= bin_n;
            bcd    <= bcd_n;
            cnt    <= cnt_n;
            out_r  <= out_n;
            busy_r <= busy_n;
            done_r <= done_n;
        end
    end

    assign bus.out  = out_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_char_conv.sv
// tb/tb_char_conv.sv - scoreboard testbench for char_conv
module tb_char_conv;
`ifdef CHAR_FAST_EN
    localparam int LAT = 15;
`else
    localparam int LAT = 30;
`endif
    localparam logic [59:0] ZERO_OUT = 60'o36363636363636363636;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [59:0] exp_q[$];

    char_conv_if #(.WIDTH(30), .DIGITS(10)) bus ();

    char_conv #(.WIDTH(30), .DIGITS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [59:0] model(input logic [29:0] v);
        logic [59:0] r;
        int unsigned t;
        t = v;
        r = '0;
        for (int k = 0; k < 10; k++) begin
            r[6*k +: 6] = 6'(30 + (t % 10));
            t = t / 10;
        end
        return r;
    endfunction

    task automatic launch(input logic [29:0] v);
        bus.start = 1'b1;
        bus.in    = v;
        exp_q.push_back(model(v));
        tick();
        bus.start = 1'b0;
    endtask

    // Scoreboard consumer: counts busy cycles, pops and compares at done
    task automatic wait_done(output int busy_cycles);
        bit seen;
        logic [59:0] e;
        seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                seen = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_done out=%o", bus.out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out !== e) begin
                        failures++;
                        $display("FAIL sb_out got=%o exp=%o", bus.out, e);
                    end
                end
            end
            tick();
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL sb_timeout no done within 100 cycles");
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL done_single got=%b exp=0", bus.done);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.in = '0;
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (bus.out !== ZERO_OUT || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got out=%o busy=%b done=%b exp out=%o busy=0 done=0",
                     bus.out, bus.busy, bus.done, ZERO_OUT);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        int bc;
        launch(30'd0);
        wait_done(bc);
        checks++;
        if (bc !== LAT) begin
            failures++;
            $display("FAIL zero_latency got=%0d exp=%0d", bc, LAT);
        end
    endtask

    task automatic test_basic();
        int bc;
        launch(30'd12977);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after_e0 got=%b exp=1", bus.busy);
        end
        wait_done(bc);
        checks++;
        if (bc !== LAT) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, LAT);
        end
        checks++;
        if (bus.out !== 60'o36363636363740474545) begin
            failures++;
            $display("FAIL basic_hold got=%o exp=%o", bus.out, 60'o36363636363740474545);
        end
    endtask

    task automatic test_max();
        int bc;
        launch(30'd1073741823);
        wait_done(bc);
        checks++;
        if (bus.out !== 60'o37364541454237464041) begin
            failures++;
            $display("FAIL max_out got=%o exp=%o", bus.out, 60'o37364541454237464041);
        end
    endtask

    task automatic test_random();
        int bc;
        for (int n = 0; n < 4; n++) begin
            launch(30'($urandom));
            wait_done(bc);
        end
    endtask

    task automatic test_ignore_busy();
        int bc;
        int extra;
        launch(30'd12977);
        repeat (9) tick();
        bus.start = 1'b1;
        bus.in = 30'd5;
        tick();
        bus.start = 1'b0;
        bus.in = '0;
        wait_done(bc);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) extra++;
            tick();
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL ignore_busy_extra_activity got=%0d exp=0", extra);
        end
        checks++;
        if (bus.out !== 60'o36363636363740474545) begin
            failures++;
            $display("FAIL ignore_busy_out got=%o exp=%o", bus.out, 60'o36363636363740474545);
        end
    endtask

    task automatic test_reset_mid();
        int bc;
        int dones;
        bus.start = 1'b1;
        bus.in = 30'd5;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== ZERO_OUT) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b out=%o exp busy=0 done=0 out=%o",
                     bus.busy, bus.done, bus.out, ZERO_OUT);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got=%0d exp=0", dones);
        end
        launch(30'd5);
        wait_done(bc);
        checks++;
        if (bus.out !== 60'o36363636363636363643) begin
            failures++;
            $display("FAIL reset_mid_restart got=%o exp=%o", bus.out, 60'o36363636363636363643);
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        logic [59:0] e;
        launch(30'd12977);
        repeat (LAT - 1) tick();
        bus.start = 1'b1;
        bus.in = 30'd5;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done got=%b exp=1", bus.done);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.out !== e) begin
                failures++;
                $display("FAIL b2b_first_out got=%o exp=%o", bus.out, e);
            end
        end
        launch(30'd99);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_busy got=%b exp=1", bus.busy);
        end
        wait_done(bc);
        checks++;
        if (bus.out !== 60'o36363636363636364747) begin
            failures++;
            $display("FAIL b2b_second_out got=%o exp=%o", bus.out, 60'o36363636363636364747);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in = '0;
        test_reset();
        test_zero();
        test_basic();
        test_max();
        test_random();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
